// File: rtl/dmem_wait_ctrl_pkg.sv
// Shared types and helpers for the wait-state data-memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int WORD_BYTES = DEF_DATA_W / 8;

  // Legal when word-aligned and nothing above the word index is set.
  function automatic logic addr_legal(input logic [63:0] addr, input int unsigned idx_w);
    return (addr[1:0] == 2'b00) && ((addr >> (idx_w + 2)) == 64'd0);
  endfunction

endpackage

// File: rtl/dmem_wait_ctrl_sram_be.sv
// Single-port RAM with byte-lane write enables and a registered, self-clearing read port.
module sram_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int NB    = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [NB-1:0]     be_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Output is zero on any cycle that did not follow a read strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= re_i ? mem_q[addr_i] : '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data memory with programmable wait states, byte-lane writes and address checking.
module dmem_wait_ctrl import mem_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_read,
  input  logic                memwrite_M,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   write_data,
  output logic [DATA_W-1:0]   read_data,
  output logic                ready,
  output logic                busy,
  output logic                addr_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_W / 8;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;
  logic              wr_q, err_q;
  logic              accept, commit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= data_addr[IDX_W+1:2];
      wdata_q <= write_data;
      be_q    <= byte_en;
      wr_q    <= memwrite_M;
      err_q   <= !addr_legal(64'(data_addr), IDX_W);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: if (mem_read || memwrite_M) begin
        accept  = 1'b1;
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT_STATES);
      end
      S_WAIT: if (cnt_q == 4'd0) begin
        commit  = 1'b1;
        state_d = S_DONE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RAM is touched only on the WAIT->DONE edge, so a reset before then drops the access.
  sram_be #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (commit && wr_q && !err_q),
    .re_i    (commit && !wr_q && !err_q),
    .be_i    (be_q),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (read_data)
  );

  assign ready    = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);
  assign addr_err = ready && err_q;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Bench: table-driven accesses with a ready-side scoreboard, plus reset and back-to-back sequences.
module tb_dmem_wait_ctrl;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0, memwrite_M = 1'b0;
  logic [3:0]  byte_en = '0;
  logic [31:0] data_addr = '0, write_data = '0;
  logic [31:0] read_data;
  logic        ready, busy, addr_err;

  logic        mem_read0 = 1'b0, memwrite0 = 1'b0;
  logic [3:0]  byte_en0 = '0;
  logic [31:0] data_addr0 = '0, write_data0 = '0;
  logic [31:0] read_data0;
  logic        ready0, busy0, addr_err0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_wait_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .memwrite_M(memwrite_M),
    .byte_en(byte_en), .data_addr(data_addr), .write_data(write_data),
    .read_data(read_data), .ready(ready), .busy(busy), .addr_err(addr_err)
  );

  dmem_wait_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .mem_read(mem_read0), .memwrite_M(memwrite0),
    .byte_en(byte_en0), .data_addr(data_addr0), .write_data(write_data0),
    .read_data(read_data0), .ready(ready0), .busy(busy0), .addr_err(addr_err0)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] edata;
    bit          eerr;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
    int          t_ready;
    string       tag;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every ready pulse of the main DUT must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.tag, "_rdata"}, read_data, e.data);
        chk({e.tag, "_err"}, 32'(addr_err), 32'(e.err));
        chk({e.tag, "_latency"}, 32'(cyc), 32'(e.t_ready));
      end
    end
  end

  task automatic access(input vec_t v, input string tag);
    int t0, nb;
    bit got;
    @(negedge clk);
    t0 = cyc;
    mem_read = v.rd; memwrite_M = v.wr; byte_en = v.be;
    data_addr = v.addr; write_data = v.wdata;
    sbq.push_back('{v.edata, v.eerr, t0 + WS + 2, tag});
    nb = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (ready) got = 1;
    end
    chk({tag, "_ready_seen"}, 32'(got), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(WS + 2));
    mem_read = 1'b0; memwrite_M = 1'b0;
  endtask

  vec_t tbl[13];

  initial begin
    int t0, nr, nr0;
    tbl[0]  = '{0, 1, 4'hF, 32'h04,  32'h12345678, 32'h0,        0};
    tbl[1]  = '{1, 0, 4'hF, 32'h04,  32'h0,        32'h12345678, 0};
    tbl[2]  = '{0, 1, 4'hF, 32'h0C,  32'h11111111, 32'h0,        0};
    tbl[3]  = '{0, 1, 4'h5, 32'h0C,  32'hAABBCCDD, 32'h0,        0};
    tbl[4]  = '{1, 0, 4'h0, 32'h0C,  32'h0,        32'h11BB11DD, 0};
    tbl[5]  = '{1, 0, 4'hF, 32'h06,  32'h0,        32'h0,        1};
    tbl[6]  = '{0, 1, 4'hF, 32'h00,  32'h0BADF00D, 32'h0,        0};
    tbl[7]  = '{0, 1, 4'hF, 32'h100, 32'hFFFFFFFF, 32'h0,        1};
    tbl[8]  = '{1, 0, 4'h0, 32'h00,  32'h0,        32'h0BADF00D, 0};
    tbl[9]  = '{1, 1, 4'hF, 32'h08,  32'h00000055, 32'h0,        0};
    tbl[10] = '{1, 0, 4'h0, 32'h08,  32'h0,        32'h00000055, 0};
    tbl[11] = '{0, 1, 4'h0, 32'h04,  32'hFFFFFFFF, 32'h0,        0};
    tbl[12] = '{1, 0, 4'h0, 32'h04,  32'h0,        32'h12345678, 0};

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) access(tbl[i], $sformatf("vec%0d", i));

    // Reset while a write sits in WAIT: the old word must survive.
    access('{0, 1, 4'hF, 32'h10, 32'hCAFEF00D, 32'h0, 0}, "pre_rst_wr");
    @(negedge clk);
    memwrite_M = 1'b1; byte_en = 4'hF; data_addr = 32'h10; write_data = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    reset = 1'b1; memwrite_M = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("post_rst_busy", 32'(busy), 32'd0);
    nr = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready) nr++;
    end
    chk("post_rst_ready_pulses", 32'(nr), 32'd0);
    access('{1, 0, 4'h0, 32'h10, 32'h0, 32'hCAFEF00D, 0}, "rst_rd");

    // Held read: a second access starts in the idle cycle after DONE.
    @(negedge clk);
    t0 = cyc;
    mem_read = 1'b1; data_addr = 32'h0C;
    sbq.push_back('{32'h11BB11DD, 0, t0 + WS + 2, "b2b_a"});
    sbq.push_back('{32'h11BB11DD, 0, t0 + 2 * WS + 5, "b2b_b"});
    nr = 0;
    for (int i = 0; i < 40 && nr < 2; i++) begin
      @(negedge clk);
      if (ready) nr++;
    end
    mem_read = 1'b0;
    chk("b2b_pulses", 32'(nr), 32'd2);

    // Zero-wait instance: combined rd+wr, then held reads spaced 3 cycles apart.
    @(negedge clk);
    t0 = cyc;
    mem_read0 = 1'b1; memwrite0 = 1'b1; byte_en0 = 4'hF; data_addr0 = 32'h08; write_data0 = 32'h55;
    nr0 = 0;
    for (int i = 0; i < 20 && nr0 < 1; i++) begin
      @(negedge clk);
      if (ready0) begin
        nr0++;
        chk("ws0_rw_latency", 32'(cyc - t0), 32'd2);
        chk("ws0_rw_rdata", read_data0, 32'd0);
        chk("ws0_rw_err", 32'(addr_err0), 32'd0);
      end
    end
    memwrite0 = 1'b0;
    chk("ws0_rw_seen", 32'(nr0), 32'd1);
    @(negedge clk);
    t0 = cyc;
    nr0 = 0;
    for (int i = 0; i < 20 && nr0 < 2; i++) begin
      @(negedge clk);
      if (ready0) begin
        nr0++;
        chk($sformatf("ws0_rd%0d_latency", nr0), 32'(cyc - t0), 32'(nr0 == 1 ? 2 : 5));
        chk($sformatf("ws0_rd%0d_rdata", nr0), read_data0, 32'h55);
      end
    end
    mem_read0 = 1'b0;
    chk("ws0_rd_pulses", 32'(nr0), 32'd2);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
